// File: rtl/pkt_desc_mq_ram.sv
// Multi-channel descriptor FIFO store on one shared 1R1W block RAM; pop-to-rd_valid latency 1 (2 with PKT_DESC_MQ_OREG_EN).
// Push to a full channel or pop of an empty channel is dropped with an error pulse; no output backpressure.
module pkt_desc_mq_ram #(
  parameter int WIDTH       = 64,
  parameter int DEPTH_NBITS = 4,
  parameter int CH_NBITS    = 2
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         push,
  input  logic [CH_NBITS-1:0]                          push_ch,
  input  logic [WIDTH-1:0]                             push_data,
  input  logic                                         pop,
  input  logic [CH_NBITS-1:0]                          pop_ch,
  output logic                                         rd_valid,
  output logic [CH_NBITS-1:0]                          rd_ch,
  output logic [WIDTH-1:0]                             rd_data,
  output logic [(1<<CH_NBITS)-1:0]                     empty,
  output logic [(1<<CH_NBITS)-1:0]                     full,
  output logic [(1<<CH_NBITS)*(DEPTH_NBITS+1)-1:0]     count,
  output logic                                         ovf_err,
  output logic                                         udf_err
);

  localparam int DEPTH  = 1 << DEPTH_NBITS;
  localparam int NUM_CH = 1 << CH_NBITS;
  localparam int CW     = DEPTH_NBITS + 1;
  localparam int AW     = CH_NBITS + DEPTH_NBITS;

  logic [DEPTH_NBITS-1:0] wr_ptr  [NUM_CH];
  logic [DEPTH_NBITS-1:0] rd_ptr  [NUM_CH];
  logic [CW-1:0]          cnt     [NUM_CH];
  logic [CW-1:0]          cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]      wr_hit;
  logic [NUM_CH-1:0]      rd_hit;
  logic [NUM_CH-1:0]      empty_q;
  logic [NUM_CH-1:0]      full_q;

  logic                   push_ok;
  logic                   pop_ok;
  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          rd_addr;

  logic [WIDTH-1:0]       mem [NUM_CH*DEPTH];
  logic [WIDTH-1:0]       ram_q;
  logic                   rd_vld_q;
  logic [CH_NBITS-1:0]    rd_ch_q;
  logic                   ovf_q;
  logic                   udf_q;

  // Acceptance is judged on registered flags only, so same-channel push+pop never bypasses.
  assign push_ok = push && !full_q[push_ch];
  assign pop_ok  = pop  && !empty_q[pop_ch];
  assign wr_addr = {push_ch, wr_ptr[push_ch]};
  assign rd_addr = {pop_ch,  rd_ptr[pop_ch]};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = push_ok && (push_ch == CH_NBITS'(i));
      rd_hit[i]  = pop_ok  && (pop_ch  == CH_NBITS'(i));
      cnt_nxt[i] = cnt[i] + CW'(wr_hit[i]) - CW'(rd_hit[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_hit[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i]     <= cnt_nxt[i];
        empty_q[i] <= (cnt_nxt[i] == '0);
        full_q[i]  <= (cnt_nxt[i] == CW'(DEPTH));
      end
    end
  end

  // Block RAM: no reset on the array or its output register.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= push_data;
    if (pop_ok)  ram_q        <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_vld_q <= pop_ok;
      if (pop_ok) rd_ch_q <= pop_ch;
      ovf_q    <= push && full_q[push_ch];
      udf_q    <= pop  && empty_q[pop_ch];
    end
  end

`ifdef PKT_DESC_MQ_OREG_EN
  logic                o_vld_q;
  logic [CH_NBITS-1:0] o_ch_q;
  logic [WIDTH-1:0]    o_dat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_vld_q <= 1'b0;
      o_ch_q  <= '0;
    end else begin
      o_vld_q <= rd_vld_q;
      if (rd_vld_q) o_ch_q <= rd_ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_q) o_dat_q <= ram_q;
  end

  assign rd_valid = o_vld_q;
  assign rd_ch    = o_ch_q;
  assign rd_data  = o_dat_q;
`else
  assign rd_valid = rd_vld_q;
  assign rd_ch    = rd_ch_q;
  assign rd_data  = ram_q;
`endif

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
  assign empty   = empty_q;
  assign full    = full_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count
    assign count[g*CW +: CW] = cnt[g];
  end

endmodule

// File: tb/tb_pkt_desc_mq_ram.sv
// Scoreboard bench: per-channel queue model, expected reads/errors queued at stimulus time, checked by a negedge monitor.
module tb_pkt_desc_mq_ram;

`ifdef PKT_DESC_MQ_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rstn;
  logic        push;
  logic [1:0]  push_ch;
  logic [63:0] push_data;
  logic        pop;
  logic [1:0]  pop_ch;
  logic        rd_valid;
  logic [1:0]  rd_ch;
  logic [63:0] rd_data;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [19:0] count;
  logic        ovf_err;
  logic        udf_err;

  pkt_desc_mq_ram dut (
    .clk(clk), .rstn(rstn),
    .push(push), .push_ch(push_ch), .push_data(push_data),
    .pop(pop), .pop_ch(pop_ch),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  typedef struct { int due; logic [1:0] ch; logic [63:0] d; } rd_t;
  typedef struct { int due; logic ovf; logic udf; } err_t;

  logic [63:0] mq [4][$];
  rd_t         rdq [$];
  err_t        errq [$];
  int          cyc;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model is advanced after the edge that samples it.
  task automatic cycle(input logic p, input logic [1:0] pc, input logic [63:0] pd,
                       input logic o, input logic [1:0] oc);
    bit pacc, oacc;
    logic [63:0] od;
    rd_t r;
    err_t e;
    push = p; push_ch = pc; push_data = pd; pop = o; pop_ch = oc;
    pacc = p && (mq[pc].size() < 16);
    oacc = o && (mq[oc].size() > 0);
    od   = oacc ? mq[oc][0] : 64'h0;
    @(posedge clk); #1;
    if (oacc) begin
      void'(mq[oc].pop_front());
      r.due = cyc + LAT - 1; r.ch = oc; r.d = od;
      rdq.push_back(r);
    end
    if (pacc) mq[pc].push_back(pd);
    e.due = cyc; e.ovf = p && !pacc; e.udf = o && !oacc;
    errq.push_back(e);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 64'h0, 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      logic [3:0]  ee, ef;
      logic [19:0] ec;
      logic        eo, eu, ev;
      rd_t         r;
      err_t        e;
      for (int i = 0; i < 4; i++) begin
        ee[i] = (mq[i].size() == 0);
        ef[i] = (mq[i].size() == 16);
        ec[i*5 +: 5] = 5'(mq[i].size());
      end
      check("empty", 64'(empty), 64'(ee));
      check("full",  64'(full),  64'(ef));
      check("count", 64'(count), 64'(ec));
      eo = 1'b0; eu = 1'b0;
      if (errq.size() > 0 && errq[0].due == cyc) begin
        e = errq.pop_front(); eo = e.ovf; eu = e.udf;
      end
      check("ovf_err", 64'(ovf_err), 64'(eo));
      check("udf_err", 64'(udf_err), 64'(eu));
      ev = (rdq.size() > 0 && rdq[0].due == cyc);
      check("rd_valid", 64'(rd_valid), 64'(ev));
      if (ev) begin
        r = rdq.pop_front();
        if (rd_valid) begin
          check("rd_ch",   64'(rd_ch), 64'(r.ch));
          check("rd_data", rd_data,    r.d);
        end
      end
    end
  end

  initial begin
    logic [1:0] a, b;
    rstn = 1'b0; cyc = 0; tests = 0; fails = 0;
    push = 1'b0; push_ch = 2'd0; push_data = 64'h0; pop = 1'b0; pop_ch = 2'd0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    check("rst_empty",    64'(empty),    64'hF);
    check("rst_full",     64'(full),     64'h0);
    check("rst_count",    64'(count),    64'h0);
    check("rst_rd_valid", 64'(rd_valid), 64'h0);
    check("rst_rd_ch",    64'(rd_ch),    64'h0);

    // Underflow on ch0.
    cycle(1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
    idle(LAT + 1);

    // Fill ch1 and drain back-to-back.
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'd1, 64'hA0 + 64'(i), 1'b0, 2'd0);
    check("full1_after_16", 64'(full[1]), 64'h1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 2'd0, 64'h0, 1'b1, 2'd1);
    idle(LAT + 1);
    check("empty1_drained", 64'(empty[1]), 64'h1);

    // ch2 full: simultaneous push/pop returns oldest, push rejected.
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'd2, {$urandom(), $urandom()}, 1'b0, 2'd0);
    cycle(1'b1, 2'd2, 64'h55, 1'b1, 2'd2);
    check("count2_15", 64'(count[10 +: 5]), 64'd15);
    @(negedge clk);
    check("ovf_full_pushpop", 64'(ovf_err), 64'h1);

    // ch3 empty: simultaneous push/pop keeps the push, pop rejected.
    cycle(1'b1, 2'd3, 64'h77, 1'b1, 2'd3);
    check("count3_1", 64'(count[15 +: 5]), 64'd1);
    @(negedge clk);
    check("udf_empty_pushpop", 64'(udf_err), 64'h1);
    cycle(1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
    idle(LAT + 1);

    // Interleave ch0/ch3 with pointer wrap.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
      b = (a == 2'd3) ? 2'd0 : 2'd3;
      cycle(($urandom_range(0, 9) < 8), a, {$urandom(), $urandom()},
            ($urandom_range(0, 9) < 6), b);
    end

    // Fully random traffic, phases biased toward fill and drain.
    for (int i = 0; i < 400; i++) begin
      int pp;
      pp = ((i / 50) % 2 == 0) ? 8 : 3;
      cycle(($urandom_range(0, 9) < pp), 2'($urandom_range(0, 3)), {$urandom(), $urandom()},
            ($urandom_range(0, 9) < (10 - pp)), 2'($urandom_range(0, 3)));
    end
    idle(LAT + 1);

    // Reset right after an accepted pop.
    cycle(1'b1, 2'd0, 64'hDEAD, 1'b0, 2'd0);
    cycle(1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_rd_valid", 64'(rd_valid), 64'h0);
    check("mid_rst_count",    64'(count),    64'h0);
    check("mid_rst_empty",    64'(empty),    64'hF);
    for (int i = 0; i < 4; i++) mq[i].delete();
    rdq.delete();
    errq.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 30; i++)
      cycle(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), {$urandom(), $urandom()},
            ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)));
    idle(LAT + 2);
    check("drain_pending_reads", 64'(rdq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
